// File: rtl/bullet_scheduler.sv
// Four-slot bullet pool for the tank game: arbitrates shoot requests from two tanks,
// spawns bullets into free slots, advances them on movement ticks and retires them.
module bullet_scheduler #(
  parameter int X_MAX = 15,
  parameter int Y_MAX = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic [1:0] req,
  input  logic [4:0] req0_x,
  input  logic [4:0] req0_y,
  input  logic [1:0] req0_dir,
  input  logic [4:0] req1_x,
  input  logic [4:0] req1_y,
  input  logic [1:0] req1_dir,
  input  logic [3:0] clr,
  output logic [4:0] bul1_x,
  output logic [4:0] bul1_y,
  output logic [4:0] bul2_x,
  output logic [4:0] bul2_y,
  output logic [4:0] bul3_x,
  output logic [4:0] bul3_y,
  output logic [4:0] bul4_x,
  output logic [4:0] bul4_y,
  output logic [3:0] bul_vld,
  output logic [1:0] gnt,
  output logic [1:0] drop
);

  localparam logic [5:0] XM = 6'(X_MAX);
  localparam logic [5:0] YM = 6'(Y_MAX);

  // One step in a direction, evaluated in 6 bits so 0-1 and MAX+1 both land out of field.
  // Result is {in_field, x[4:0], y[4:0]}.
  function automatic logic [10:0] step_cell(input logic [4:0] x, input logic [4:0] y,
                                            input logic [1:0] d);
    logic [5:0] nx;
    logic [5:0] ny;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (d)
      2'b00:   ny = ny + 6'd1;
      2'b01:   ny = ny - 6'd1;
      2'b10:   nx = nx + 6'd1;
      default: nx = nx - 6'd1;
    endcase
    return {(nx <= XM) && (ny <= YM), nx[4:0], ny[4:0]};
  endfunction

  logic [4:0]  pos_x [4];
  logic [4:0]  pos_y [4];
  logic [1:0]  dir_q [4];
  logic [3:0]  vld;
  logic [1:0]  req_d;
  logic [1:0]  pend;
  logic        last;

  logic [1:0]  rise;
  logic [1:0]  want;
  logic [1:0]  serve_mask;
  logic        serve;
  logic        tie;
  logic        who;
  logic [4:0]  src_x;
  logic [4:0]  src_y;
  logic [1:0]  src_dir;
  logic [10:0] spawn;
  logic [10:0] mv [4];
  logic        free_found;
  logic [1:0]  free_idx;
  logic        alloc;

  always_comb begin
    rise       = req & ~req_d;
    want       = pend | rise;
    serve      = en & (|want);
    tie        = &want;
    who        = tie ? ~last : want[1];
    src_x      = who ? req1_x : req0_x;
    src_y      = who ? req1_y : req0_y;
    src_dir    = who ? req1_dir : req0_dir;
    spawn      = step_cell(src_x, src_y, src_dir);
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!vld[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
    alloc      = serve & free_found & spawn[10];
    serve_mask = serve ? (who ? 2'b10 : 2'b01) : 2'b00;
    for (int i = 0; i < 4; i++) begin
      mv[i] = step_cell(pos_x[i], pos_y[i], dir_q[i]);
    end
  end

  // The round-robin pointer only moves on a contested cycle, so a tie is always
  // awarded to the requester that lost the previous tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pos_x[i] <= 5'h1F;
        pos_y[i] <= 5'h1F;
        dir_q[i] <= 2'b00;
      end
      vld   <= 4'b0000;
      req_d <= 2'b00;
      pend  <= 2'b00;
      last  <= 1'b0;
      gnt   <= 2'b00;
      drop  <= 2'b00;
    end else begin
      req_d <= req;
      pend  <= want & ~serve_mask;
      gnt   <= alloc ? serve_mask : 2'b00;
      drop  <= alloc ? 2'b00 : serve_mask;
      if (serve && tie) begin
        last <= who;
      end
      for (int i = 0; i < 4; i++) begin
        if (vld[i] && clr[i]) begin
          vld[i]   <= 1'b0;
          pos_x[i] <= 5'h1F;
          pos_y[i] <= 5'h1F;
        end else if (vld[i] && tick && en) begin
          if (mv[i][10]) begin
            pos_x[i] <= mv[i][9:5];
            pos_y[i] <= mv[i][4:0];
          end else begin
            vld[i]   <= 1'b0;
            pos_x[i] <= 5'h1F;
            pos_y[i] <= 5'h1F;
          end
        end else if (alloc && free_idx == 2'(i)) begin
          vld[i]   <= 1'b1;
          pos_x[i] <= spawn[9:5];
          pos_y[i] <= spawn[4:0];
          dir_q[i] <= src_dir;
        end
      end
    end
  end

  assign bul1_x  = pos_x[0];
  assign bul1_y  = pos_y[0];
  assign bul2_x  = pos_x[1];
  assign bul2_y  = pos_y[1];
  assign bul3_x  = pos_x[2];
  assign bul3_y  = pos_y[2];
  assign bul4_x  = pos_x[3];
  assign bul4_y  = pos_y[3];
  assign bul_vld = vld;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a slot-list model of the game rules.
module tb_bullet_scheduler;

  localparam int X_MAX = 15;
  localparam int Y_MAX = 19;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       tick;
  logic [1:0] req;
  logic [4:0] req0_x, req0_y, req1_x, req1_y;
  logic [1:0] req0_dir, req1_dir;
  logic [3:0] clr;
  logic [4:0] bul1_x, bul1_y, bul2_x, bul2_y, bul3_x, bul3_y, bul4_x, bul4_y;
  logic [3:0] bul_vld;
  logic [1:0] gnt, drop;

  logic [4:0] dut_x [4];
  logic [4:0] dut_y [4];

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: plain integer cells per slot, free slots parked at 31.
  bit         m_vld [4];
  int         m_x [4] = '{31, 31, 31, 31};
  int         m_y [4] = '{31, 31, 31, 31};
  int         m_dir [4];
  bit [1:0]   m_pend, m_reqd, m_gnt, m_drop;
  bit         m_last;

  bullet_scheduler #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .req(req),
    .req0_x(req0_x), .req0_y(req0_y), .req0_dir(req0_dir),
    .req1_x(req1_x), .req1_y(req1_y), .req1_dir(req1_dir),
    .clr(clr),
    .bul1_x(bul1_x), .bul1_y(bul1_y), .bul2_x(bul2_x), .bul2_y(bul2_y),
    .bul3_x(bul3_x), .bul3_y(bul3_y), .bul4_x(bul4_x), .bul4_y(bul4_y),
    .bul_vld(bul_vld), .gnt(gnt), .drop(drop)
  );

  assign dut_x[0] = bul1_x;
  assign dut_x[1] = bul2_x;
  assign dut_x[2] = bul3_x;
  assign dut_x[3] = bul4_x;
  assign dut_y[0] = bul1_y;
  assign dut_y[1] = bul2_y;
  assign dut_y[2] = bul3_y;
  assign dut_y[3] = bul4_y;

  always #5 clk = ~clk;

  function automatic int ddx(input int d);
    return (d == 2) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int ddy(input int d);
    return (d == 0) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  function automatic bit in_field(input int x, input int y);
    return x >= 0 && x <= X_MAX && y >= 0 && y <= Y_MAX;
  endfunction

  task automatic check_lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic free_slot(input int i);
    m_vld[i] = 1'b0;
    m_x[i]   = 31;
    m_y[i]   = 31;
  endtask

  // One clock edge of the game rules, using the slot contents as they were before the edge.
  task automatic model_step();
    bit [1:0] rise, want, served;
    int who, slot, sx, sy, sd, tx, ty, nx, ny;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        free_slot(i);
        m_dir[i] = 0;
      end
      m_pend = 0; m_reqd = 0; m_gnt = 0; m_drop = 0; m_last = 0;
      return;
    end
    rise   = req & ~m_reqd;
    m_reqd = req;
    want   = m_pend | rise;
    served = 0;
    m_gnt  = 0;
    m_drop = 0;
    slot   = -1;
    sd     = 0;
    tx     = 0;
    ty     = 0;
    if (en && want != 0) begin
      if (want == 2'b11) begin
        who    = m_last ? 0 : 1;
        m_last = (who == 1);
      end else begin
        who = want[1] ? 1 : 0;
      end
      served[who] = 1'b1;
      sx = (who == 1) ? int'(req1_x) : int'(req0_x);
      sy = (who == 1) ? int'(req1_y) : int'(req0_y);
      sd = (who == 1) ? int'(req1_dir) : int'(req0_dir);
      tx = sx + ddx(sd);
      ty = sy + ddy(sd);
      for (int i = 0; i < 4; i++) if (!m_vld[i] && slot < 0) slot = i;
      if (slot >= 0 && in_field(tx, ty)) m_gnt[who] = 1'b1;
      else m_drop[who] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i] && clr[i]) begin
        free_slot(i);
      end else if (m_vld[i] && tick && en) begin
        nx = m_x[i] + ddx(m_dir[i]);
        ny = m_y[i] + ddy(m_dir[i]);
        if (in_field(nx, ny)) begin
          m_x[i] = nx;
          m_y[i] = ny;
        end else begin
          free_slot(i);
        end
      end
    end
    if (m_gnt != 0) begin
      m_vld[slot] = 1'b1;
      m_x[slot]   = tx;
      m_y[slot]   = ty;
      m_dir[slot] = sd;
    end
    m_pend = want & ~served;
  endtask

  task automatic check_output();
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) ev[i] = m_vld[i];
    check_lit("bul_vld", int'(bul_vld), int'(ev));
    check_lit("gnt", int'(gnt), int'(m_gnt));
    check_lit("drop", int'(drop), int'(m_drop));
    for (int i = 0; i < 4; i++) begin
      check_lit($sformatf("bul%0d_x", i + 1), int'(dut_x[i]), m_x[i]);
      check_lit($sformatf("bul%0d_y", i + 1), int'(dut_y[i]), m_y[i]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check_output();
  end

  task automatic apply_stimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_p0(input int x, input int y, input int d);
    req0_x = 5'(x); req0_y = 5'(y); req0_dir = 2'(d);
  endtask

  task automatic set_p1(input int x, input int y, input int d);
    req1_x = 5'(x); req1_y = 5'(y); req1_dir = 2'(d);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; req = 2'b00; clr = 4'b0000;
    set_p0(0, 0, 0);
    set_p1(0, 0, 0);
    apply_stimulus(2);
    check_lit("reset_vld", int'(bul_vld), 0);
    check_lit("reset_bul1_x", int'(bul1_x), 31);
    rst_n = 1'b1;
    en    = 1'b1;

    // Single shot and three ticks of travel.
    set_p0(5, 5, 0);
    req = 2'b01;
    apply_stimulus(1);
    check_lit("single_gnt", int'(gnt), 1);
    check_lit("single_pos_y", int'(bul1_y), 6);
    req = 2'b00;
    for (int t = 0; t < 3; t++) begin
      tick = 1'b1; apply_stimulus(1);
      tick = 1'b0; apply_stimulus(1);
    end
    check_lit("travel_x", int'(bul1_x), 5);
    check_lit("travel_y", int'(bul1_y), 9);
    clr = 4'b0001; apply_stimulus(1); clr = 4'b0000;

    // Tie: enemy first, then player; the next tie goes to the player.
    set_p0(3, 3, 2);
    set_p1(8, 8, 1);
    req = 2'b11; apply_stimulus(1);
    check_lit("tie1_gnt", int'(gnt), 2);
    check_lit("tie1_y", int'(bul1_y), 7);
    apply_stimulus(1);
    check_lit("tie1_loser_gnt", int'(gnt), 1);
    check_lit("tie1_loser_x", int'(bul2_x), 4);
    req = 2'b00; apply_stimulus(1);
    clr = 4'b0011; apply_stimulus(1); clr = 4'b0000;
    req = 2'b11; apply_stimulus(1);
    check_lit("tie2_gnt", int'(gnt), 1);
    check_lit("tie2_x", int'(bul1_x), 4);
    apply_stimulus(1);
    check_lit("tie2_loser_gnt", int'(gnt), 2);
    req = 2'b00; apply_stimulus(1);

    // Fill the pool, overflow, then reuse a cleared slot.
    for (int k = 0; k < 2; k++) begin
      req = 2'b01; apply_stimulus(1);
      req = 2'b00; apply_stimulus(1);
    end
    check_lit("full_vld", int'(bul_vld), 15);
    req = 2'b01; apply_stimulus(1);
    check_lit("full_drop", int'(drop), 1);
    check_lit("full_vld_kept", int'(bul_vld), 15);
    req = 2'b00; clr = 4'b0100; apply_stimulus(1); clr = 4'b0000;
    check_lit("clr_vld", int'(bul_vld), 11);
    req = 2'b01; apply_stimulus(1);
    check_lit("reuse_vld", int'(bul_vld), 15);
    check_lit("reuse_bul3_x", int'(bul3_x), 4);
    req = 2'b00; clr = 4'b1111; apply_stimulus(1); clr = 4'b0000;

    // Field edges: spawn off the left edge, retire off the right edge.
    set_p0(0, 4, 3);
    req = 2'b01; apply_stimulus(1);
    check_lit("edge_drop", int'(drop), 1);
    check_lit("edge_vld", int'(bul_vld), 0);
    req = 2'b00; set_p0(14, 7, 2); apply_stimulus(1);
    req = 2'b01; apply_stimulus(1);
    check_lit("edge_spawn_x", int'(bul1_x), 15);
    req = 2'b00; tick = 1'b1; apply_stimulus(1); tick = 1'b0;
    check_lit("edge_retire_vld", int'(bul_vld), 0);
    check_lit("edge_retire_x", int'(bul1_x), 31);

    // Clear beats movement; a fresh bullet ignores the same-edge tick.
    set_p0(5, 9, 0);
    req = 2'b01; apply_stimulus(1);
    req = 2'b00; clr = 4'b0001; tick = 1'b1; apply_stimulus(1);
    clr = 4'b0000; tick = 1'b0;
    check_lit("clr_vs_tick_y", int'(bul1_y), 31);
    apply_stimulus(1);
    req = 2'b01; tick = 1'b1; apply_stimulus(1);
    check_lit("spawn_vs_tick_y", int'(bul1_y), 10);
    req = 2'b00; tick = 1'b0; clr = 4'b0001; apply_stimulus(1); clr = 4'b0000;

    // Enable low freezes movement and defers the grant; reset wipes the pool.
    set_p0(2, 2, 0);
    req = 2'b01; apply_stimulus(1);
    req = 2'b00; en = 1'b0; tick = 1'b1; apply_stimulus(1); tick = 1'b0;
    check_lit("frozen_y", int'(bul1_y), 3);
    req = 2'b01; apply_stimulus(1);
    check_lit("disabled_gnt", int'(gnt), 0);
    en = 1'b1; apply_stimulus(1);
    check_lit("deferred_gnt", int'(gnt), 1);
    check_lit("deferred_vld", int'(bul_vld), 3);
    req = 2'b00; rst_n = 1'b0; apply_stimulus(1);
    check_lit("midreset_vld", int'(bul_vld), 0);
    rst_n = 1'b1; apply_stimulus(1);

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] vmask;
      for (int i = 0; i < 4; i++) vmask[i] = m_vld[i];
      req   = 2'($urandom_range(0, 3));
      set_p0($urandom_range(0, 17), $urandom_range(0, 21), $urandom_range(0, 3));
      set_p1($urandom_range(0, 17), $urandom_range(0, 21), $urandom_range(0, 3));
      tick  = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 7) != 0);
      clr   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15))
              & 4'($urandom_range(0, 15)) & vmask;
      rst_n = ($urandom_range(0, 199) != 0);
      apply_stimulus(1);
    end
    rst_n = 1'b1; req = 2'b00; tick = 1'b0; clr = 4'b0000;
    apply_stimulus(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
